// File: rtl/pipo_pkg.sv
// Shared types and sizing helpers for the round-robin PIPO write controller.
package pipo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int HOLD_W = 8;

  function automatic int owner_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipo_rr_ctrl_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick
  import pipo_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]          req,
  input  logic [owner_w(NREQ)-1:0] ptr,
  output logic [owner_w(NREQ)-1:0] win,
  output logic                     any
);

  localparam int OWNER_W = owner_w(NREQ);

  logic [4:0] idx;

  // Scan offsets from the far end back towards ptr so the closest hit is written last.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = 5'(ptr) + 5'(k);
      if (idx >= 5'(NREQ)) idx = idx - 5'(NREQ);
      if (req[OWNER_W'(idx)]) begin
        win = OWNER_W'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipo_rr_ctrl.sv
// Round-robin write controller sharing one holding register among NREQ requesters,
// holding each captured word for HOLD_CYCLES cycles before arbitrating again.
module pipo_rr_ctrl
  import pipo_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          grant,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [owner_w(NREQ)-1:0] q_owner,
  output logic                     busy
);

  localparam int                  OWNER_W   = owner_w(NREQ);
  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [OWNER_W-1:0]  LAST      = OWNER_W'(NREQ - 1);

  state_t              state;
  logic [OWNER_W-1:0]  rr_ptr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [OWNER_W-1:0]  win;
  logic                any;
  logic [WIDTH-1:0]    win_data;
  logic [NREQ-1:0]     win_onehot;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .win (win),
    .any (any)
  );

  // Constant-index mux keeps the data select free of variable part-selects.
  always_comb begin
    win_data   = '0;
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == OWNER_W'(i)) begin
        win_data      = req_data[i*WIDTH +: WIDTH];
        win_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      q_owner  <= '0;
      grant    <= '0;
      busy     <= 1'b0;
    end else if (clr) begin
      // Flush aborts any hold; the pointer keeps its place so fairness survives a flush.
      state   <= IDLE;
      q       <= '0;
      q_valid <= 1'b0;
      grant   <= '0;
      busy    <= 1'b0;
    end else begin
      grant <= '0;
      unique case (state)
        IDLE: begin
          if (any) begin
            q        <= win_data;
            q_owner  <= win;
            q_valid  <= 1'b1;
            grant    <= win_onehot;
            rr_ptr   <= (win == LAST) ? '0 : win + 1'b1;
            hold_cnt <= HOLD_LOAD;
            state    <= HOLD;
            busy     <= 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_busy_valid:   assert property (@(posedge clk) disable iff (rst) busy |-> q_valid);

endmodule

// File: tb/tb_pipo_rr_ctrl.sv
// Bench for pipo_rr_ctrl: vector tables, a round-robin sequence and randomized model comparison.
module tb_pipo_rr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NREQ=4, HOLD_CYCLES=2
  logic        rst, clr;
  logic [3:0]  req_a;
  logic [15:0] data_a;
  logic [3:0]  grant_a, q_a;
  logic        v_a, busy_a;
  logic [1:0]  owner_a;

  // Instance B: NREQ=3, HOLD_CYCLES=1
  logic        rst_b, clr_b;
  logic [2:0]  req_b;
  logic [11:0] data_b;
  logic [2:0]  grant_b;
  logic [3:0]  q_b;
  logic        v_b, busy_b;
  logic [1:0]  owner_b;

  pipo_rr_ctrl #(.WIDTH(4), .NREQ(4), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .req(req_a), .req_data(data_a),
    .grant(grant_a), .q(q_a), .q_valid(v_a), .q_owner(owner_a), .busy(busy_a)
  );

  pipo_rr_ctrl #(.WIDTH(4), .NREQ(3), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst_b), .clr(clr_b), .req(req_b), .req_data(data_b),
    .grant(grant_b), .q(q_b), .q_valid(v_b), .q_owner(owner_b), .busy(busy_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int rst; int clr; int req; int data;
    int grant; int q; int valid; int owner; int busy;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  task automatic run_row(input bit on_b, input vec_t v, input string tag);
    if (!on_b) begin
      rst = v.rst[0]; clr = v.clr[0]; req_a = v.req[3:0]; data_a = v.data[15:0];
    end else begin
      rst_b = v.rst[0]; clr_b = v.clr[0]; req_b = v.req[2:0]; data_b = v.data[11:0];
    end
    @(posedge clk); #1;
    if (!on_b) begin
      chk({tag, " grant"}, int'(grant_a), v.grant);
      chk({tag, " q"},     int'(q_a),     v.q);
      chk({tag, " valid"}, int'(v_a),     v.valid);
      chk({tag, " owner"}, int'(owner_a), v.owner);
      chk({tag, " busy"},  int'(busy_a),  v.busy);
    end else begin
      chk({tag, " grant"}, int'(grant_b), v.grant);
      chk({tag, " q"},     int'(q_b),     v.q);
      chk({tag, " valid"}, int'(v_b),     v.valid);
      chk({tag, " owner"}, int'(owner_b), v.owner);
      chk({tag, " busy"},  int'(busy_b),  v.busy);
    end
  endtask

  // Reference model: hold_left counts edges still owed to the current word.
  typedef struct { int ptr; int hold_left; int q; int valid; int owner; int grant; } mst_t;

  function automatic mst_t mstep(mst_t s, int n, int hold, bit r, bit c,
                                 int req, logic [63:0] data, int wd);
    mst_t t;
    t = s;
    t.grant = 0;
    if (r) begin
      t = '{default: 0};
      return t;
    end
    if (c) begin
      t.q = 0; t.valid = 0; t.hold_left = 0;
      return t;
    end
    if (t.hold_left > 0) begin
      t.hold_left--;
      return t;
    end
    for (int k = 0; k < n; k++) begin
      int i;
      i = (s.ptr + k) % n;
      if (((req >> i) & 1) != 0) begin
        t.q         = int'((data >> (i * wd)) & ((64'd1 << wd) - 64'd1));
        t.owner     = i;
        t.valid     = 1;
        t.grant     = 1 << i;
        t.ptr       = (i + 1) % n;
        t.hold_left = hold;
        return t;
      end
    end
    return t;
  endfunction

  mst_t ma, mb;

  initial begin
    int gidx[$];
    int gcyc[$];
    int gq[$];
    logic [3:0] dropped;

    rst = 1'b1; clr = 1'b0; req_a = '0; data_a = '0;
    rst_b = 1'b1; clr_b = 1'b0; req_b = '0; data_b = '0;

    // rst, clr, req, data, grant, q, valid, owner, busy
    tbl_a.push_back('{1, 0, 'hF, 'h4A21, 0, 0,   0, 0, 0});
    tbl_a.push_back('{1, 0, 'hF, 'h4A21, 0, 0,   0, 0, 0});
    tbl_a.push_back('{0, 0, 'hF, 'h4A21, 1, 1,   1, 0, 1});
    tbl_a.push_back('{0, 0, 'h0, 'h4A21, 0, 1,   1, 0, 1});
    tbl_a.push_back('{0, 0, 'h0, 'h4A21, 0, 1,   1, 0, 0});
    tbl_a.push_back('{0, 0, 'h4, 'h4A21, 4, 'hA, 1, 2, 1});
    tbl_a.push_back('{0, 0, 'h0, 'h4A21, 0, 'hA, 1, 2, 1});
    tbl_a.push_back('{0, 0, 'h0, 'h4A21, 0, 'hA, 1, 2, 0});
    tbl_a.push_back('{0, 0, 'h2, 'h4A21, 2, 2,   1, 1, 1});
    tbl_a.push_back('{0, 0, 'h8, 'h4A21, 0, 2,   1, 1, 1});
    tbl_a.push_back('{0, 0, 'h8, 'h4A21, 0, 2,   1, 1, 0});
    tbl_a.push_back('{0, 0, 'h8, 'h4A21, 8, 4,   1, 3, 1});
    tbl_a.push_back('{0, 0, 'h0, 'h4A21, 0, 4,   1, 3, 1});
    tbl_a.push_back('{0, 1, 'h1, 'h4A21, 0, 0,   0, 3, 0});
    tbl_a.push_back('{0, 0, 'h1, 'h4A21, 1, 1,   1, 0, 1});
    tbl_a.push_back('{1, 1, 'h1, 'h4A21, 0, 0,   0, 0, 0});
    tbl_a.push_back('{0, 0, 'h2, 'h4A21, 2, 2,   1, 1, 1});
    tbl_a.push_back('{0, 0, 'h0, 'h4A21, 0, 2,   1, 1, 1});
    tbl_a.push_back('{0, 0, 'h0, 'h4A21, 0, 2,   1, 1, 0});
    tbl_a.push_back('{0, 1, 'hF, 'h4A21, 0, 0,   0, 1, 0});
    tbl_a.push_back('{0, 0, 'hF, 'h4A21, 4, 'hA, 1, 2, 1});

    tbl_b.push_back('{1, 0, 'h7, 'h321, 0, 0, 0, 0, 0});
    tbl_b.push_back('{0, 0, 'h2, 'h321, 2, 2, 1, 1, 1});
    tbl_b.push_back('{0, 0, 'h0, 'h321, 0, 2, 1, 1, 0});
    tbl_b.push_back('{0, 0, 'h3, 'h321, 1, 1, 1, 0, 1});
    tbl_b.push_back('{0, 0, 'h2, 'h321, 0, 1, 1, 0, 0});
    tbl_b.push_back('{0, 0, 'h2, 'h321, 2, 2, 1, 1, 1});
    tbl_b.push_back('{0, 0, 'h0, 'h321, 0, 2, 1, 1, 0});
    tbl_b.push_back('{0, 0, 'h4, 'h321, 4, 3, 1, 2, 1});
    tbl_b.push_back('{0, 0, 'h0, 'h321, 0, 3, 1, 2, 0});
    tbl_b.push_back('{0, 0, 'h7, 'h321, 1, 1, 1, 0, 1});

    foreach (tbl_a[i]) run_row(1'b0, tbl_a[i], $sformatf("a_row%0d", i));
    foreach (tbl_b[i]) run_row(1'b1, tbl_b[i], $sformatf("b_row%0d", i));

    // Round-robin with requesters dropping req for one edge after seeing their grant.
    rst = 1'b1; clr = 1'b0; req_a = 4'hF; data_a = 16'h4321;
    @(posedge clk); #1;
    rst = 1'b0;
    dropped = '0;
    for (int cyc = 0; cyc < 30 && gidx.size() < 5; cyc++) begin
      req_a = 4'hF & ~dropped;
      @(posedge clk); #1;
      dropped = grant_a;
      if (grant_a != '0) begin
        for (int i = 0; i < 4; i++) if (grant_a[i]) gidx.push_back(i);
        gcyc.push_back(cyc);
        gq.push_back(int'(q_a));
      end
    end
    chk("rr grant count", gidx.size(), 5);
    for (int k = 0; k < gidx.size(); k++) begin
      chk($sformatf("rr grant%0d idx", k), gidx[k], k % 4);
      chk($sformatf("rr grant%0d q", k), gq[k], (k % 4) + 1);
      if (k > 0) chk($sformatf("rr grant%0d spacing", k), gcyc[k] - gcyc[k-1], 3);
    end

    // Randomized run of both instances against the reference model.
    ma = '{default: 0};
    mb = '{default: 0};
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst    = (cyc == 0) || ($urandom_range(0, 63) == 0);
      clr    = ($urandom_range(0, 11) == 0);
      req_a  = 4'($urandom_range(0, 15));
      data_a = 16'($urandom);
      rst_b  = (cyc == 0) || ($urandom_range(0, 63) == 0);
      clr_b  = ($urandom_range(0, 11) == 0);
      req_b  = 3'($urandom_range(0, 7));
      data_b = 12'($urandom);
      ma = mstep(ma, 4, 2, rst, clr, int'(req_a), {48'd0, data_a}, 4);
      mb = mstep(mb, 3, 1, rst_b, clr_b, int'(req_b), {52'd0, data_b}, 4);
      @(posedge clk); #1;
      chk($sformatf("rand%0d a grant", cyc), int'(grant_a), ma.grant);
      chk($sformatf("rand%0d a q", cyc),     int'(q_a),     ma.q);
      chk($sformatf("rand%0d a valid", cyc), int'(v_a),     ma.valid);
      chk($sformatf("rand%0d a owner", cyc), int'(owner_a), ma.owner);
      chk($sformatf("rand%0d a busy", cyc),  int'(busy_a),  int'(ma.hold_left > 0));
      chk($sformatf("rand%0d b grant", cyc), int'(grant_b), mb.grant);
      chk($sformatf("rand%0d b q", cyc),     int'(q_b),     mb.q);
      chk($sformatf("rand%0d b valid", cyc), int'(v_b),     mb.valid);
      chk($sformatf("rand%0d b owner", cyc), int'(owner_b), mb.owner);
      chk($sformatf("rand%0d b busy", cyc),  int'(busy_b),  int'(mb.hold_left > 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
